// File: rtl/lcd_if.sv
// LSU-side LCD MMIO channel: one-cycle store strobe with data word, plus the status word read back.
interface lcd_if;
    logic [31:0] lcd_wdata;
    logic        lcd_vld;
    logic [31:0] status;

    modport master (output lcd_wdata, output lcd_vld, input  status);
    modport slave  (input  lcd_wdata, input  lcd_vld, output status);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller: buffers LSU stores in a command FIFO and replays them
// on the LCD pins with setup / enable / hold / execution timing.
module lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 4,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_CLEAR_CYC = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    lcd_if.slave       lsu,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_lcd_blon
);

    localparam int unsigned AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned T_M1  = (T_SETUP_CYC > T_EN_CYC)   ? T_SETUP_CYC : T_EN_CYC;
    localparam int unsigned T_M2  = (T_HOLD_CYC  > T_EXEC_CYC) ? T_HOLD_CYC  : T_EXEC_CYC;
    localparam int unsigned T_M3  = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int unsigned T_MAX = (T_M3 > T_CLEAR_CYC) ? T_M3 : T_CLEAR_CYC;
    localparam int unsigned CNT_W = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENHI,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_overflow;
    logic             r_busy;
    logic             r_full;

    logic             w_ctrl;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_ovf_set;
    logic             w_is_clear;
    logic             w_unused_bits;

    // Word decode: bit 31 selects the control path, otherwise a command for the FIFO
    assign w_ctrl        = lsu.lcd_vld &  lsu.lcd_wdata[31];
    assign w_push_req    = lsu.lcd_vld & ~lsu.lcd_wdata[31];
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_push        = w_push_req & (~w_full | w_pop);
    assign w_ovf_set     = w_push_req & w_full & ~w_pop;
    assign w_is_clear    = ~o_lcd_rs & (o_lcd_data[7:2] == 6'd0) & (o_lcd_data != 8'd0);
    assign w_unused_bits = ^lsu.lcd_wdata[30:9];

    assign o_lcd_rw   = 1'b0;
    assign lsu.status = {27'd0, r_overflow, r_full, r_busy, 2'd0};

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= lsu.lcd_wdata[8:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Each timed state exits when the down-counter, loaded with N-1 on entry, reaches zero
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SETUP;
                    w_next_cnt   = CNT_W'(T_SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_ENHI;
                    w_next_cnt   = CNT_W'(T_EN_CYC - 1);
                end
            end
            ST_ENHI: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = CNT_W'(T_HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_WAIT;
                    w_next_cnt   = w_is_clear ? CNT_W'(T_CLEAR_CYC - 1) : CNT_W'(T_EXEC_CYC - 1);
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Pin and status registers; E follows the next state so it lines up with ENHI
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_lcd_data <= 8'd0;
            o_lcd_rs   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_lcd_blon <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            o_lcd_en <= (w_next_state == ST_ENHI);
            if (w_pop) begin
                o_lcd_rs   <= r_mem[r_rd_ptr][8];
                o_lcd_data <= r_mem[r_rd_ptr][7:0];
            end
            if (w_ctrl) begin
                o_lcd_on   <= lsu.lcd_wdata[1];
                o_lcd_blon <= lsu.lcd_wdata[0];
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ctrl && lsu.lcd_wdata[2]) begin
                r_overflow <= 1'b0;
            end
            r_busy <= (r_state != ST_IDLE) | ~w_empty;
            r_full <= w_full;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened LCD timings and a 4-entry FIFO.
module tb_lcd_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       lcd_blon;
    int         n_vec;
    int         n_err;
    int         cyc;

    lcd_if bus ();

    lcd_ctrl #(
        .FIFO_DEPTH (4),
        .T_SETUP_CYC(2),
        .T_EN_CYC   (3),
        .T_HOLD_CYC (2),
        .T_EXEC_CYC (5),
        .T_CLEAR_CYC(20)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .lsu       (bus),
        .o_lcd_data(lcd_data),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_rw  (lcd_rw),
        .o_lcd_en  (lcd_en),
        .o_lcd_on  (lcd_on),
        .o_lcd_blon(lcd_blon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc < k) tick();
    endtask

    // Drives a one-cycle store in the current cycle and moves on to the next
    task automatic push(input logic [31:0] w);
        bus.lcd_wdata = w;
        bus.lcd_vld   = 1'b1;
        tick();
        bus.lcd_vld   = 1'b0;
        bus.lcd_wdata = 32'd0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        bus.lcd_wdata = 32'd0;
        bus.lcd_vld   = 1'b0;
        rst = 1'b1;
        #12;
        chk("rst_status", bus.status, 32'd0);
        chk("rst_pins", {22'd0, lcd_data, lcd_rs, lcd_rw}, 32'd0);
        chk("rst_en_on", {29'd0, lcd_en, lcd_on, lcd_blon}, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // 1: single data write and its E window
        cyc = 0;
        push(32'h0000_0141);
        tick();
        chk("t1_rsdata_c2", {23'd0, lcd_rs, lcd_data}, 32'h141);
        chk("t1_en_c2", {31'd0, lcd_en}, 32'd0);
        goto(3);  chk("t1_en_c3", {31'd0, lcd_en}, 32'd0);
        goto(4);  chk("t1_en_c4", {31'd0, lcd_en}, 32'd1);
        goto(6);  chk("t1_en_c6", {31'd0, lcd_en}, 32'd1);
        goto(7);  chk("t1_en_c7", {31'd0, lcd_en}, 32'd0);
        chk("t1_hold_c7", {23'd0, lcd_rs, lcd_data}, 32'h141);
        goto(13); chk("t1_status_c13", bus.status, 32'h4);
        goto(16); chk("t1_status_c16", bus.status, 32'h0);
        chk("t1_rw", {31'd0, lcd_rw}, 32'd0);

        // 2: clear command stretches WAIT before the queued function-set runs
        cyc = 0;
        push(32'h0000_0001);
        push(32'h0000_0038);
        chk("t2_rsdata_c2", {23'd0, lcd_rs, lcd_data}, 32'h001);
        goto(20); chk("t2_still_clear_c20", {23'd0, lcd_rs, lcd_data}, 32'h001);
        goto(28); chk("t2_en_c28", {31'd0, lcd_en}, 32'd0);
        goto(30); chk("t2_rsdata_c30", {23'd0, lcd_rs, lcd_data}, 32'h038);
        goto(31); chk("t2_en_c31", {31'd0, lcd_en}, 32'd0);
        goto(32); chk("t2_en_c32", {31'd0, lcd_en}, 32'd1);
        goto(35); chk("t2_en_c35", {31'd0, lcd_en}, 32'd0);
        goto(45); chk("t2_status_idle", bus.status, 32'h0);

        // 3: overflow while busy, in-order drain, sticky flag cleared by control word
        cyc = 0;
        push(32'h0000_0130);
        tick();
        for (int i = 1; i <= 6; i++) push(32'h0000_0140 + 32'(i));
        goto(8);  chk("t3_status_c8", bus.status, 32'h1C);
        goto(15); chk("t3_w1_c15", {23'd0, lcd_rs, lcd_data}, 32'h141);
        goto(28); chk("t3_w2_c28", {23'd0, lcd_rs, lcd_data}, 32'h142);
        goto(41); chk("t3_w3_c41", {23'd0, lcd_rs, lcd_data}, 32'h143);
        goto(54); chk("t3_w4_c54", {23'd0, lcd_rs, lcd_data}, 32'h144);
        goto(67); chk("t3_no_w5_c67", {23'd0, lcd_rs, lcd_data}, 32'h144);
        goto(70); chk("t3_status_c70", bus.status, 32'h10);
        push(32'h8000_0004);
        chk("t3_ovf_clear", bus.status, 32'h0);

        // 4: control word during E high leaves the transfer alone
        cyc = 0;
        push(32'h0000_0141);
        goto(4);
        push(32'h8000_0003);
        chk("t4_on_blon_c5", {30'd0, lcd_on, lcd_blon}, 32'd3);
        chk("t4_en_c5", {31'd0, lcd_en}, 32'd1);
        goto(6);  chk("t4_en_c6", {31'd0, lcd_en}, 32'd1);
        goto(7);  chk("t4_en_c7", {31'd0, lcd_en}, 32'd0);
        goto(8);  chk("t4_hold_c8", {23'd0, lcd_rs, lcd_data}, 32'h141);
        goto(20); chk("t4_status_idle", bus.status, 32'h0);

        // 6: push into a full FIFO in the same cycle as the IDLE pop
        cyc = 0;
        push(32'h0000_0050);
        tick();
        for (int i = 1; i <= 4; i++) push(32'h0000_0050 + 32'(i));
        goto(14);
        push(32'h0000_0055);
        goto(16); chk("t6_status_c16", bus.status, 32'h0C);
        goto(67); chk("t6_w5_c67", {23'd0, lcd_rs, lcd_data}, 32'h055);
        goto(82); chk("t6_status_idle", bus.status, 32'h0);

        // 5: reset mid-pulse drops E without a clock edge and empties the FIFO
        cyc = 0;
        push(32'h0000_0141);
        push(32'h0000_0142);
        goto(5);
        chk("t5_en_before", {31'd0, lcd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_en_async", {31'd0, lcd_en}, 32'd0);
        chk("t5_status", bus.status, 32'h0);
        chk("t5_pins", {22'd0, lcd_data, lcd_rs, lcd_on}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t5_after_en_data", {23'd0, lcd_en, lcd_data}, 32'd0);
        chk("t5_after_status", bus.status, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
